// File: rtl/spi_slave_pkg.sv
// Shared types and defaults for the SPI mode-0 slave.
// Edge bundle produced by each input synchroniser.
package spi_slave_pkg;

  localparam int SPI_WIDTH       = 8;
  localparam int SYNC_STAGES_DEF = 2;

  typedef struct packed {
    logic lvl;
    logic rise;
    logic fall;
  } edge_t;

endpackage

// File: rtl/spi_slave_sync.sv
// Single-bit synchroniser with one history flop.
// Reports the synchronised level plus rise/fall strobes.
module sync_edge
  import spi_slave_pkg::*;
#(
  parameter int   STAGES  = SYNC_STAGES_DEF,
  parameter logic RST_VAL = 1'b0
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  d_i,
  output edge_t e_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;
  logic              lvl;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign lvl = sync_q[STAGES-1];

  always_comb begin
    e_o.lvl  = lvl;
    e_o.rise = lvl & ~hist_q;
    e_o.fall = ~lvl & hist_q;
  end

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, byte oriented.
// All SPI pins are sampled and edge-detected in the clk domain.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] txdata,
  output logic [WIDTH-1:0] rxdata,
  output logic             rxready,
  input  logic             mosi,
  output logic             miso,
  input  logic             sck,
  input  logic             ss
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  edge_t sck_e;
  edge_t ss_e;
  edge_t mosi_e;

  // Presets keep sck low and ss high so reset release makes no edge.
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (sck),
    .e_o    (sck_e)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (ss),
    .e_o    (ss_e)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (mosi),
    .e_o    (mosi_e)
  );

  logic unused_edges;
  assign unused_edges = ^{sck_e.lvl, ss_e.rise,
                          mosi_e.rise, mosi_e.fall};

  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rxdata_q, rxdata_d;
  logic             rxready_q, rxready_d;

  logic             sel;
  logic             last_bit;
  logic             at_bound;
  logic [WIDTH-1:0] rx_next;

  assign sel      = ~ss_e.lvl;
  assign last_bit = (bitcnt_q == CW'(WIDTH - 1));
  assign at_bound = (bitcnt_q == '0);
  assign rx_next  = {rx_sr_q[WIDTH-2:0], mosi_e.lvl};

  always_comb begin
    bitcnt_d  = bitcnt_q;
    rx_sr_d   = rx_sr_q;
    tx_sr_d   = tx_sr_q;
    rxdata_d  = rxdata_q;
    rxready_d = 1'b0;

    if (!sel) begin
      bitcnt_d = '0;
    end else if (sck_e.rise) begin
      rx_sr_d = rx_next;
      if (last_bit) begin
        bitcnt_d  = '0;
        rxdata_d  = rx_next;
        rxready_d = 1'b1;
      end else begin
        bitcnt_d = bitcnt_q + 1'b1;
      end
    end

    // Frame start outranks a coincident falling SCK.
    if (ss_e.fall) begin
      tx_sr_d = txdata;
    end else if (sel && sck_e.fall) begin
      if (at_bound) begin
        tx_sr_d = txdata;
      end else begin
        tx_sr_d = {tx_sr_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bitcnt_q  <= '0;
      rx_sr_q   <= '0;
      tx_sr_q   <= '0;
      rxdata_q  <= '0;
      rxready_q <= 1'b0;
    end else begin
      bitcnt_q  <= bitcnt_d;
      rx_sr_q   <= rx_sr_d;
      tx_sr_q   <= tx_sr_d;
      rxdata_q  <= rxdata_d;
      rxready_q <= rxready_d;
    end
  end

  assign rxdata  = rxdata_q;
  assign rxready = rxready_q;
  assign miso    = tx_sr_q[WIDTH-1];

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: SPI master model, byte scoreboard and
// per-cycle output checks against expected received bytes.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] txdata;
  logic [7:0] rxdata;
  logic       rxready;
  logic       mosi = 1'b0;
  logic       miso;
  logic       sck = 1'b0;
  logic       ss = 1'b1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] tx_plan [16];
  logic [7:0] msg [16];
  logic [7:0] got_log [16];
  int         rx_count   = 0;
  int         frame_base = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_last = 8'h00;

  always #5 clk = ~clk;

  // Consumer: next reply byte advances on every rxready.
  assign txdata = tx_plan[4'(rx_count - frame_base)];

  spi_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .txdata  (txdata),
    .rxdata  (rxdata),
    .rxready (rxready),
    .mosi    (mosi),
    .miso    (miso),
    .sck     (sck),
    .ss      (ss)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      exp_last = 8'h00;
      chk("rst_rxready", 32'(rxready), 0);
      chk("rst_rxdata", 32'(rxdata), 0);
      chk("rst_miso", 32'(miso), 0);
    end else begin
      if (rxready) begin
        if (exp_q.size() == 0)
          chk("spurious_rxready", 32'(rxready), 0);
        else
          exp_last = exp_q.pop_front();
        rx_count++;
      end
      chk("rxdata", 32'(rxdata), 32'(exp_last));
    end
  end

  task automatic spi_bits(input logic [7:0] b,
                          input int nb,
                          input int hp,
                          output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nb; i++) begin
      mosi = b[7-i];
      #(hp * 10);
      sck = 1'b1;
      got = {got[6:0], miso};
      if (i == 7) exp_q.push_back(b);
      #(hp * 10);
      sck = 1'b0;
    end
  endtask

  task automatic frame(input int nb, input int part,
                       input int hp);
    logic [7:0] got;
    frame_base = rx_count;
    ss = 1'b0;
    #(hp * 10);
    for (int k = 0; k < nb; k++) begin
      spi_bits(msg[k], 8, hp, got);
      got_log[k] = got;
      chk("miso_byte", 32'(got), 32'(tx_plan[k]));
    end
    if (part > 0)
      spi_bits(8'($urandom), part, hp, got);
    #(hp * 10);
    ss = 1'b1;
    #(hp * 20);
    chk("frame_drained", 32'(exp_q.size()), 0);
  endtask

  initial begin
    int c0;
    logic [7:0] junk;
    for (int i = 0; i < 16; i++) begin
      tx_plan[i] = 8'h00;
      msg[i]     = 8'h00;
      got_log[i] = 8'h00;
    end
    #3;
    repeat (6) begin
      sck = ~sck;
      #30;
      ss = ~ss;
      #20;
    end
    sck = 1'b0;
    ss  = 1'b1;
    #20;
    rst = 1'b1;
    #100;

    msg[0] = 8'hA5;
    tx_plan[0] = 8'h3C;
    c0 = rx_count;
    frame(1, 0, 10);
    chk("a5_pulses", 32'(rx_count - c0), 1);
    chk("a5_rxdata", 32'(rxdata), 32'h A5);
    chk("a5_miso", 32'(got_log[0]), 32'h3C);

    msg[0] = 8'h10; msg[1] = 8'h01; msg[2] = 8'h00;
    msg[3] = 8'h00; msg[4] = 8'h01; msg[5] = 8'hF4;
    for (int i = 0; i < 16; i++)
      tx_plan[i] = 8'($urandom);
    c0 = rx_count;
    frame(6, 0, 10);
    chk("six_pulses", 32'(rx_count - c0), 6);
    chk("six_rxdata", 32'(rxdata), 32'hF4);

    c0 = rx_count;
    frame(0, 5, 10);
    chk("partial_pulses", 32'(rx_count - c0), 0);
    msg[0] = 8'h81;
    frame(1, 0, 10);
    chk("p81_pulses", 32'(rx_count - c0), 1);
    chk("p81_rxdata", 32'(rxdata), 32'h81);

    c0 = rx_count;
    repeat (16) begin
      sck = ~sck;
      #100;
    end
    chk("desel_pulses", 32'(rx_count - c0), 0);
    chk("desel_rxdata", 32'(rxdata), 32'h81);

    frame_base = rx_count;
    tx_plan[0] = 8'hFF;
    ss = 1'b0;
    #100;
    spi_bits(8'hC3, 5, 10, junk);
    mosi = 1'b1;
    sck = 1'b1;
    #40;
    rst = 1'b0;
    #1;
    chk("mid_rst_rxdata", 32'(rxdata), 0);
    chk("mid_rst_rxready", 32'(rxready), 0);
    chk("mid_rst_miso", 32'(miso), 0);
    sck = 1'b0;
    ss  = 1'b1;
    #50;
    rst = 1'b1;
    #100;
    msg[0] = 8'h5A;
    c0 = rx_count;
    frame(1, 0, 10);
    chk("r5a_pulses", 32'(rx_count - c0), 1);
    chk("r5a_rxdata", 32'(rxdata), 32'h5A);

    for (int f = 0; f < 25; f++) begin
      int nb;
      int part;
      int hp;
      nb   = int'($urandom_range(1, 5));
      part = ($urandom_range(0, 3) == 0) ?
             int'($urandom_range(1, 7)) : 0;
      hp   = int'($urandom_range(5, 12));
      for (int i = 0; i < 16; i++) begin
        msg[i]     = 8'($urandom);
        tx_plan[i] = 8'($urandom);
      end
      c0 = rx_count;
      frame(nb, part, hp);
      chk("rand_pulses", 32'(rx_count - c0), 32'(nb));
      chk("rand_rxdata", 32'(rxdata), 32'(msg[nb-1]));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
